echo_cancel: RTL and testbench

ECHO_CANCEL -- requirements
Module: echo_cancel

---
 rtl/reverb_pkg.sv | 17 +
 rtl/echo_cancel_if.sv | 24 ++
 rtl/echo_hist_ram.sv | 26 ++
 rtl/echo_cancel.sv | 107 ++++++++++
 tb/tb_echo_cancel.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/reverb_pkg.sv
// Shared constants and helpers for the reverb/echo-cancel datapaths.
package reverb_pkg;

   localparam int unsigned GAIN_FRAC_BITS = 4;
   localparam int unsigned MAX_DATA_WIDTH = 64;

   // Largest signed value representable in 'width' bits, zero-extended.
   function automatic logic [MAX_DATA_WIDTH-1:0] sat_max(input int unsigned width);
      return (MAX_DATA_WIDTH'(1) << (width - 1)) - MAX_DATA_WIDTH'(1);
   endfunction

   // Smallest signed value representable in 'width' bits, sign-extended.
   function automatic logic [MAX_DATA_WIDTH-1:0] sat_min(input int unsigned width);
      return ~sat_max(width);
   endfunction

endpackage

// File: rtl/echo_cancel_if.sv
// Sample stream into and out of the echo canceller; no backpressure.
interface echo_cancel_if
   import reverb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                            in_valid;
   logic signed [DATA_WIDTH-1:0]    in_data;
   logic [GAIN_FRAC_BITS-1:0]       gain;
   logic                            out_valid;
   logic signed [DATA_WIDTH-1:0]    out_data;

   modport master (
      output in_valid, in_data, gain,
      input  out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, gain,
      output out_valid, out_data
   );

endinterface

// File: rtl/echo_hist_ram.sv
// History buffer: one synchronous read port, one write port, read-before-write on collision.
module echo_hist_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024
) (
   input  logic                          clk,
   input  logic                          rd_en,
   input  logic [$clog2(DEPTH)-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0]         rd_data,
   input  logic                          wr_en,
   input  logic [$clog2(DEPTH)-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/echo_cancel.sv
// Inverse echo stage: x[n] = y[n] - ((g * x[n-DELAY_DEPTH]) >>> 4), two-cycle pipeline.
// Define ECHO_CANCEL_SAT_EN to saturate the result instead of wrapping it.
module echo_cancel
   import reverb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DELAY_DEPTH = 1024
) (
   input logic          clk,
   input logic          reset_n,
   echo_cancel_if.slave bus
);

   localparam int unsigned PtrWidth  = $clog2(DELAY_DEPTH);
   localparam int unsigned FillWidth = PtrWidth + 1;
   localparam int unsigned ProdWidth = DATA_WIDTH + GAIN_FRAC_BITS;
   localparam int unsigned DiffWidth = DATA_WIDTH + 1;
   localparam logic [FillWidth-1:0] FillFull = FillWidth'(DELAY_DEPTH);

   logic [PtrWidth-1:0]             wr_ptr_q;
   logic [FillWidth-1:0]            fill_q;
   logic                            s1_valid_q;
   logic signed [DATA_WIDTH-1:0]    s1_data_q;
   logic [GAIN_FRAC_BITS-1:0]       s1_gain_q;
   logic [PtrWidth-1:0]             s1_ptr_q;
   logic                            s1_full_q;
   logic                            out_valid_q;
   logic signed [DATA_WIDTH-1:0]    out_data_q;

   logic signed [DATA_WIDTH-1:0]    hist_rd;
   logic signed [ProdWidth-1:0]     prod;
   logic signed [DiffWidth-1:0]     delayed;
   logic signed [DiffWidth-1:0]     diff;
   logic signed [DATA_WIDTH-1:0]    x_res;

`ifdef ECHO_CANCEL_SAT_EN
   localparam logic [DATA_WIDTH-1:0] SatMax = DATA_WIDTH'(sat_max(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] SatMin = DATA_WIDTH'(sat_min(DATA_WIDTH));
`endif

   echo_hist_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DELAY_DEPTH)
   ) u_hist (
      .clk     (clk),
      .rd_en   (bus.in_valid),
      .rd_addr (wr_ptr_q),
      .rd_data (hist_rd),
      .wr_en   (s1_valid_q),
      .wr_addr (s1_ptr_q),
      .wr_data (x_res)
   );

   always_comb begin
      // Until DELAY_DEPTH samples exist the RAM holds stale data, so the echo term is masked.
      prod = '0;
      if (s1_full_q) begin
         prod = signed'({{GAIN_FRAC_BITS{hist_rd[DATA_WIDTH-1]}}, hist_rd})
              * signed'({{DATA_WIDTH{1'b0}}, s1_gain_q});
      end
      delayed = DiffWidth'(prod >>> GAIN_FRAC_BITS);
      diff    = signed'({s1_data_q[DATA_WIDTH-1], s1_data_q}) - delayed;
`ifdef ECHO_CANCEL_SAT_EN
      if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
         x_res = diff[DATA_WIDTH] ? SatMin : SatMax;
      end else begin
         x_res = diff[DATA_WIDTH-1:0];
      end
`else
      x_res = DATA_WIDTH'(diff);
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_gain_q   <= '0;
         s1_ptr_q    <= '0;
         s1_full_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         s1_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            s1_data_q <= bus.in_data;
            s1_gain_q <= bus.gain;
            s1_ptr_q  <= wr_ptr_q;
            s1_full_q <= (fill_q == FillFull);
            wr_ptr_q  <= wr_ptr_q + PtrWidth'(1);
            if (fill_q != FillFull) begin
               fill_q <= fill_q + FillWidth'(1);
            end
         end
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q <= x_res;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_echo_cancel.sv
// Self-checking bench for echo_cancel (DATA_WIDTH=32, DELAY_DEPTH=4).
// Honours ECHO_CANCEL_SAT_EN for the expected result reduction.
`timescale 1ns/1ps
module tb_echo_cancel;

   localparam int unsigned DW = 32;
   localparam int unsigned DD = 4;

   typedef struct {
      longint val;
      longint due;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   echo_cancel_if #(.DATA_WIDTH(DW)) bus ();

   echo_cancel #(
      .DATA_WIDTH  (DW),
      .DELAY_DEPTH (DD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   longint      cyc      = 0;
   longint      last_out = 0;
   longint      hist[$];
   exp_t        exp_q[$];
   longint      got[$];

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: recovered samples since reset, plain integer arithmetic.
   function automatic longint model_step(input longint y, input int g);
      longint xd;
      longint x;
      longint hi;
      longint lo;
      hi = longint'(32'sh7fff_ffff);
      lo = longint'(32'sh8000_0000);
      xd = (hist.size() >= DD) ? hist[hist.size() - DD] : 0;
      x  = y - ((g * xd) >>> 4);
`ifdef ECHO_CANCEL_SAT_EN
      if (x > hi) x = hi;
      else if (x < lo) x = lo;
`else
      x = longint'(int'(x));
`endif
      hist.push_back(x);
      return x;
   endfunction

   always @(posedge clk) begin
      if (reset_n && bus.in_valid) begin
         exp_q.push_back('{val: model_step(longint'(bus.in_data), int'(bus.gain)), due: cyc + 2});
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         hist.delete();
         last_out <= 0;
         check("reset_valid", {63'd0, bus.out_valid}, 0);
         check("reset_data", bus.out_data, 0);
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         check("out_valid", {63'd0, bus.out_valid}, 1);
         check("out_data", bus.out_data, exp_q[0].val);
         got.push_back(longint'(bus.out_data));
         last_out <= exp_q[0].val;
         void'(exp_q.pop_front());
      end else begin
         check("idle_valid", {63'd0, bus.out_valid}, 0);
         check("hold_data", bus.out_data, last_out);
      end
   end

   task automatic send(input longint y, input int g);
      bus.in_valid = 1'b1;
      bus.in_data  = y[31:0];
      bus.gain     = 4'(g);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 10) begin
         @(posedge clk);
         #1;
         k++;
      end
      idle(1);
      check("drain_timeout", exp_q.size(), 0);
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      idle(n);
      reset_n = 1'b1;
      got.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

   longint impulse_exp[8];
   longint orig[$];
   longint y;
   longint x;
   longint sat_exp;
   int     nbad;

   initial begin
      impulse_exp = '{1000, 0, 0, 0, -500, 0, 0, 0};
      bus.in_valid = 1'b1;
      bus.in_data  = 123;
      bus.gain     = 4'd5;
      reset_n      = 1'b0;
      // Reset held with in_valid high; first accepted sample comes right after release.
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      drain();
      check("reset_first_count", got.size(), 1);
      check("reset_first_value", got[0], 123);

      // Impulse, continuous valid
      do_reset(2);
      send(1000, 8);
      for (int i = 0; i < 7; i++) send(0, 8);
      drain();
      check("impulse_count", got.size(), 8);
      for (int i = 0; i < 8; i++) check("impulse_value", got[i], impulse_exp[i]);

      // Impulse with random gaps
      do_reset(2);
      send(1000, 8);
      idle(int'($urandom_range(0, 5)));
      for (int i = 0; i < 7; i++) begin
         send(0, 8);
         idle(int'($urandom_range(0, 5)));
      end
      drain();
      check("gap_count", got.size(), 8);
      for (int i = 0; i < 8; i++) check("gap_value", got[i], impulse_exp[i]);

      // Saturation / wrap with most negative stored sample
      do_reset(2);
      send(longint'(32'sh8000_0000), 0);
      send(1, 0);
      send(2, 0);
      send(3, 0);
      send(longint'(32'sh7fff_ffff), 15);
      drain();
`ifdef ECHO_CANCEL_SAT_EN
      sat_exp = longint'(32'sh7fff_ffff);
`else
      sat_exp = longint'(32'shf7ff_ffff);
`endif
      check("sat_count", got.size(), 5);
      check("sat_value", got[4], sat_exp);

      // Mid-stream reset discards in-flight samples, fill masks stale RAM
      do_reset(2);
      for (int i = 0; i < 6; i++) send(10 + i, 15);
      do_reset(2);
      send(77, 15);
      for (int i = 1; i < 12; i++) send(100 * i, 15);
      drain();
      check("midreset_count", got.size(), 12);
      check("midreset_first", got[0], 77);
      check("midreset_wrap4", got[4], 328);
      check("midreset_wrap8", got[8], 493);

      // Round trip through the feed-forward reverb stage, g=12
      do_reset(2);
      for (int i = 0; i < 4096; i++) begin
         x = longint'($urandom_range(0, 32'h1fff_ffff)) - 64'sd268435456;
         y = x + ((12 * ((i >= 4) ? orig[i - 4] : 0)) >>> 4);
         orig.push_back(x);
         send(y, 12);
      end
      drain();
      check("roundtrip_count", got.size(), 4096);
      nbad = 0;
      for (int i = 0; i < 4096; i++) begin
         if (got[i] != orig[i]) nbad++;
      end
      check("roundtrip_mismatches", nbad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
